// File: rtl/axi_node_wrr_arbiter.sv
// Weighted round-robin arbiter for one AXI address channel (weights enabled by AXI_NODE_WRR_WEIGHT_EN).
// Latency: zero cycles, grant and payload are combinational from inputs and state.
// Backpressure: a stalled grant is locked until its handshake, so the payload stays stable.
module axi_node_wrr_arbiter #(
    parameter int unsigned N_MASTER     = 4,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned AUX_WIDTH    = 1,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter int unsigned IDX_WIDTH    = $clog2(N_MASTER)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_MASTER*WEIGHT_WIDTH-1:0] cfg_weight_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]     inp_id_i,
    input  logic [N_MASTER*AUX_WIDTH-1:0]    inp_aux_i,
    input  logic [N_MASTER-1:0]              inp_valid_i,
    output logic [N_MASTER-1:0]              inp_ready_o,
    output logic [ID_WIDTH-1:0]              oup_id_o,
    output logic [AUX_WIDTH-1:0]             oup_aux_o,
    output logic [IDX_WIDTH-1:0]             oup_idx_o,
    output logic                             oup_valid_o,
    input  logic                             oup_ready_i
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]           state_q;
    logic [IDX_WIDTH-1:0] rr_ptr_q;
    logic [IDX_WIDTH-1:0] lock_idx_q;
    logic [IDX_WIDTH-1:0] search_idx;
    logic [IDX_WIDTH-1:0] sel;
    logic [IDX_WIDTH-1:0] next_ptr;
    logic [IDX_WIDTH:0]   cand;
    logic                 hs;

    logic [ID_WIDTH-1:0]  id_arr  [N_MASTER];
    logic [AUX_WIDTH-1:0] aux_arr [N_MASTER];

    for (genvar i = 0; i < N_MASTER; i++) begin : g_unpack
        assign id_arr[i]  = inp_id_i[i*ID_WIDTH +: ID_WIDTH];
        assign aux_arr[i] = inp_aux_i[i*AUX_WIDTH +: AUX_WIDTH];
    end

    // Walk offsets from high to low so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        search_idx = rr_ptr_q;
        cand       = '0;
        for (int k = N_MASTER - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(k);
            if (cand >= (IDX_WIDTH+1)'(N_MASTER)) begin
                cand = cand - (IDX_WIDTH+1)'(N_MASTER);
            end
            if (inp_valid_i[cand[IDX_WIDTH-1:0]]) begin
                search_idx = cand[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        if (rst_i) begin
            sel         = '0;
            oup_valid_o = 1'b0;
        end else if (state_q == LOCKED) begin
            sel         = lock_idx_q;
            oup_valid_o = inp_valid_i[lock_idx_q];
        end else begin
            sel         = search_idx;
            oup_valid_o = |inp_valid_i;
        end
    end

    assign hs        = oup_valid_o && oup_ready_i;
    assign oup_idx_o = sel;
    assign oup_id_o  = id_arr[sel];
    assign oup_aux_o = aux_arr[sel];
    assign next_ptr  = (sel == IDX_WIDTH'(N_MASTER - 1)) ? '0 : sel + IDX_WIDTH'(1);

    always_comb begin
        inp_ready_o = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            inp_ready_o[i] = hs && (sel == IDX_WIDTH'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else if (state_q == IDLE) begin
            if (oup_valid_o && !oup_ready_i) begin
                state_q    <= LOCKED;
                lock_idx_q <= sel;
            end
        end else if (hs) begin
            state_q <= IDLE;
        end
    end

`ifdef AXI_NODE_WRR_WEIGHT_EN
    logic [IDX_WIDTH-1:0]    owner_q;
    logic [WEIGHT_WIDTH-1:0] cnt_q;
    logic [WEIGHT_WIDTH-1:0] weight_arr [N_MASTER];
    logic [WEIGHT_WIDTH-1:0] eff_w;
    logic [WEIGHT_WIDTH:0]   n_grant;
    logic                    turn_done;

    for (genvar i = 0; i < N_MASTER; i++) begin : g_weight
        assign weight_arr[i] = cfg_weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // A zero weight still grants one transaction per turn.
    assign eff_w     = (weight_arr[sel] == '0) ? WEIGHT_WIDTH'(1) : weight_arr[sel];
    assign n_grant   = (sel == owner_q) ? {1'b0, cnt_q} + (WEIGHT_WIDTH+1)'(1)
                                        : (WEIGHT_WIDTH+1)'(1);
    assign turn_done = n_grant >= {1'b0, eff_w};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else if (hs) begin
            owner_q <= sel;
            if (turn_done) begin
                cnt_q    <= '0;
                rr_ptr_q <= next_ptr;
            end else begin
                cnt_q    <= n_grant[WEIGHT_WIDTH-1:0];
                rr_ptr_q <= sel;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^cfg_weight_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (hs) begin
            rr_ptr_q <= next_ptr;
        end
    end
`endif

endmodule

// File: tb/tb_axi_node_wrr_arbiter.sv
// Directed table-driven bench for axi_node_wrr_arbiter; expectations follow the build's weighting mode.
module tb_axi_node_wrr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cfg_weight_i;
    logic [15:0] inp_id_i;
    logic [3:0]  inp_aux_i;
    logic [3:0]  inp_valid_i;
    logic [3:0]  inp_ready_o;
    logic [3:0]  oup_id_o;
    logic [0:0]  oup_aux_o;
    logic [1:0]  oup_idx_o;
    logic        oup_valid_o;
    logic        oup_ready_i;

    axi_node_wrr_arbiter #(
        .N_MASTER(4), .ID_WIDTH(4), .AUX_WIDTH(1), .WEIGHT_WIDTH(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_weight_i(cfg_weight_i),
        .inp_id_i(inp_id_i), .inp_aux_i(inp_aux_i), .inp_valid_i(inp_valid_i),
        .inp_ready_o(inp_ready_o), .oup_id_o(oup_id_o), .oup_aux_o(oup_aux_o),
        .oup_idx_o(oup_idx_o), .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [15:0] w;
        logic [3:0]  vld;
        logic        rdy;
        logic        exp_vld;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur_row  = 0;
    int   fair_seq[10];
    int   flat_seq[5];
    int   drop_seq[3];

    function automatic void add(logic rst, logic [15:0] w, logic [3:0] vld, logic rdy,
                                logic exp_vld, logic [1:0] exp_idx);
        vec_t v;
        v.rst = rst; v.w = w; v.vld = vld; v.rdy = rdy;
        v.exp_vld = exp_vld; v.exp_idx = exp_idx;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, cur_row, act, exp);
        end
    endtask

    task automatic run_row(vec_t v);
        logic [3:0] exp_rdy;
        logic [3:0] exp_id;
        rst_i        = v.rst;
        cfg_weight_i = v.w;
        inp_valid_i  = v.vld;
        oup_ready_i  = v.rdy;
        exp_rdy      = (v.rdy && v.exp_vld) ? (4'b0001 << v.exp_idx) : 4'b0000;
        exp_id       = 4'd9 + {2'b00, v.exp_idx};
        @(negedge clk_i);
        chk("oup_valid", 32'(oup_valid_o), 32'(v.exp_vld));
        chk("oup_idx",   32'(oup_idx_o),   32'(v.exp_idx));
        chk("inp_ready", 32'(inp_ready_o), 32'(exp_rdy));
        chk("oup_id",    32'(oup_id_o),    32'(exp_id));
        chk("oup_aux",   32'(oup_aux_o),   32'(v.exp_idx[0]));
        @(posedge clk_i);
        #1;
        cur_row++;
    endtask

    initial begin
        vec_t v;
        rst_i        = 1'b1;
        cfg_weight_i = '0;
        inp_id_i     = {4'hC, 4'hB, 4'hA, 4'h9};
        inp_aux_i    = 4'b1010;
        inp_valid_i  = '0;
        oup_ready_i  = 1'b0;

`ifdef AXI_NODE_WRR_WEIGHT_EN
        fair_seq = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
        flat_seq = '{0, 0, 0, 1, 1};
        drop_seq = '{1, 1, 2};
`else
        fair_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        flat_seq = '{0, 1, 2, 3, 0};
        drop_seq = '{2, 1, 2};
`endif

        // Reset holds outputs quiet with every master requesting, then weights {1,2,3,1}.
        add(1, 16'h1321, 4'b1111, 1, 0, 0);
        add(1, 16'h1321, 4'b1111, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 16'h1321, 4'b1111, 1, 1, 2'(fair_seq[i]));
        // Equal weights of three.
        add(1, 16'h3333, 4'b1111, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 16'h3333, 4'b1111, 1, 1, 2'(flat_seq[i]));
        // Zero weights with wrap: park rr_ptr at 3, then alternate 3/0.
        add(1, 16'h0000, 4'b0000, 1, 0, 0);
        add(0, 16'h0000, 4'b0100, 1, 1, 2);
        add(0, 16'h0000, 4'b1001, 1, 1, 3);
        add(0, 16'h0000, 4'b1001, 1, 1, 0);
        add(0, 16'h0000, 4'b1001, 1, 1, 3);
        add(0, 16'h0000, 4'b1001, 1, 1, 0);
        // Master 1 (weight 3) drops mid-turn, then its next turn restarts at n = 1.
        add(1, 16'h0030, 4'b0000, 1, 0, 0);
        add(0, 16'h0030, 4'b0010, 1, 1, 1);
        add(0, 16'h0030, 4'b0100, 1, 1, 2);
        add(0, 16'h0030, 4'b0010, 1, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 16'h0030, 4'b0110, 1, 1, 2'(drop_seq[i]));
        // Stalled grant on master 2 stays put while master 0 joins.
        add(1, 16'h0000, 4'b0000, 0, 0, 0);
        add(0, 16'h0000, 4'b0100, 0, 1, 2);
        add(0, 16'h0000, 4'b0100, 0, 1, 2);
        add(0, 16'h0000, 4'b0101, 0, 1, 2);
        add(0, 16'h0000, 4'b0101, 0, 1, 2);
        add(0, 16'h0000, 4'b0101, 0, 1, 2);
        add(0, 16'h0000, 4'b0101, 1, 1, 2);
        add(0, 16'h0000, 4'b0101, 1, 1, 0);

        @(posedge clk_i);
        #1;
        foreach (tbl[i]) run_row(tbl[i]);

        // Reset while locked on master 0 drops the lock without a handshake.
        v.w = '0;
        v.rst = 1; v.vld = 4'b0000; v.rdy = 0; v.exp_vld = 0; v.exp_idx = 0; run_row(v);
        v.rst = 0; v.vld = 4'b0001; v.rdy = 0; v.exp_vld = 1; v.exp_idx = 0; run_row(v);
        v.rst = 1; v.vld = 4'b0100; v.rdy = 1; v.exp_vld = 0; v.exp_idx = 0; run_row(v);
        v.rst = 0; v.vld = 4'b0100; v.rdy = 1; v.exp_vld = 1; v.exp_idx = 2; run_row(v);

        // Locked master withdrawing valid: output goes invalid, grant does not move.
        v.rst = 0; v.vld = 4'b0001; v.rdy = 0; v.exp_vld = 1; v.exp_idx = 0; run_row(v);
        v.rst = 0; v.vld = 4'b0010; v.rdy = 1; v.exp_vld = 0; v.exp_idx = 0; run_row(v);
        v.rst = 0; v.vld = 4'b0011; v.rdy = 1; v.exp_vld = 1; v.exp_idx = 0; run_row(v);
        v.rst = 0; v.vld = 4'b0011; v.rdy = 1; v.exp_vld = 1; v.exp_idx = 1; run_row(v);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_node_wrr_arbiter.md
# axi_node_wrr_arbiter

Weighted round-robin arbiter for one AXI address channel (AW or AR) inside the AXI node. It shares a single slave-side address port between N_MASTER requesting masters. Each master keeps the grant for up to a run-time programmable number of back-to-back transactions. The grant is locked while the output is stalled, so that the ID/aux payload stays stable as the AXI handshake rules require.

## Interface
- N_MASTER, 4, number of requesting masters (>= 2)
- ID_WIDTH, 4, width of the transaction ID
- AUX_WIDTH, 1, width of the auxiliary payload (address/len/etc. packed by the caller; >= 1)
- WEIGHT_WIDTH, 4, width of each per-master weight
- IDX_WIDTH, $clog2(N_MASTER), width of the grant index (derived)

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- cfg_weight_i  in  N_MASTER×WEIGHT_WIDTH  transactions per turn for each master; 0 is treated as 1
- inp_id_i  in  N_MASTER×ID_WIDTH  per-master ID
- inp_aux_i  in  N_MASTER×AUX_WIDTH  per-master payload
- inp_valid_i  in  N_MASTER  per-master request valid
- inp_ready_o  out  N_MASTER  per-master ready
- oup_id_o  out  ID_WIDTH  ID of the granted master
- oup_aux_o  out  AUX_WIDTH  payload of the granted master
- oup_idx_o  out  IDX_WIDTH  index of the granted master (used for response routing)
- oup_valid_o  out  1  output valid
- oup_ready_i  in  1  output ready

## Operation
- Registered state:
  - FSM {IDLE, LOCKED}.
  - rr_ptr (IDX_WIDTH): highest-priority master.
  - owner (IDX_WIDTH): master whose grants are being counted.
  - cnt (WEIGHT_WIDTH): grants issued to owner in the current turn.
  - lock_idx (IDX_WIDTH): held grant while LOCKED.
- IDLE:
  - sel is the first set bit of inp_valid_i, searching upward from rr_ptr and wrapping at N_MASTER-1 → 0.
  - oup_valid_o = |inp_valid_i.
  - The output muxes select sel.
- LOCKED:
  - sel = lock_idx; the priority search is ignored.
  - oup_valid_o = inp_valid_i[lock_idx].
- inp_ready_o[i] = oup_ready_i && oup_valid_o && (sel == i). At most one bit is set.
- IDLE → LOCKED: when oup_valid_o && !oup_ready_i; lock_idx <= sel.
- LOCKED → IDLE: on the handshake (oup_valid_o && oup_ready_i).
- Handshake on master g, with eff_w = max(cfg_weight_i[g], 1):
  - If g == owner, n = cnt + 1; otherwise n = 1 and owner <= g.
  - If n >= eff_w: cnt <= 0 and rr_ptr <= (g+1) mod N_MASTER (wraps N_MASTER-1 → 0).
  - Otherwise: cnt <= n and rr_ptr <= g, so the same master keeps priority.
- cnt saturates; it cannot exceed eff_w - 1. Weight changes take effect on the next handshake comparison.
- If the requester at rr_ptr drops valid mid-turn, the search moves on. The next grant goes to a different master, which starts a new turn with n = 1.

## Timing
- Zero-cycle latency: the grant and output payload are combinational from inputs and state in the same cycle.
- No combinational path from oup_ready_i to oup_valid_o.
- LOCKED guarantees a stable sel and payload until the handshake.
  - A locked master deasserting valid is a protocol violation.
  - In that case the block stays LOCKED with oup_valid_o = 0. It does not re-arbitrate.
- While rst_i = 1:
  - oup_valid_o = 0, inp_ready_o = 0.
  - oup_idx_o, oup_id_o and oup_aux_o follow master 0.
  - On the next edge: FSM = IDLE, rr_ptr = 0, owner = 0, cnt = 0, lock_idx = 0.
- Reset asserted mid-transaction (LOCKED) abandons the lock immediately, with no handshake.
- A simultaneous handshake and new request from another master is permitted: the updated rr_ptr applies in the next cycle only.
- Back-to-back handshakes are allowed every cycle.

## Configuration
- AXI_NODE_WRR_WEIGHT_EN defined: weighted behaviour as above.
- AXI_NODE_WRR_WEIGHT_EN undefined:
  - cfg_weight_i is ignored, eff_w = 1, and cnt/owner are removed.
  - Every handshake on g sets rr_ptr <= (g+1) mod N_MASTER, giving plain round-robin.
- The IDLE/LOCKED lock logic is present in both builds.

## Test plan
- Reset/idle: rst_i = 1 with all inp_valid_i = 4'b1111 → oup_valid_o = 0 and inp_ready_o = 0. After release, the first grant goes to index 0.
- Weighted fairness: weights {1,2,3,1} for masters 0..3, all valid continuously, oup_ready_i = 1 → grant sequence 0,1,1,2,2,2,3, then repeats.
- Lock: master 2 only valid, oup_ready_i = 0 for 5 cycles, with master 0 raising valid at cycle 2 → oup_idx_o = 2 and the ID is stable all 5 cycles. The handshake goes to 2 on ready; master 0 is granted next.
- Wrap and zero weight: weights all 0, valid = 4'b1001, rr_ptr starting at 3 → grants 3,0,3,0, i.e. weight 0 behaves as 1.
- Mid-turn drop: weight[1] = 3; master 1 is granted once, then drops valid while master 2 is valid → master 2 is granted with n = 1. Master 1's turn restarts when it next wins.
- Macro off: weights {3,3,3,3}, all valid → grants 0,1,2,3,0. Reset asserted during LOCKED → FSM returns to IDLE and oup_valid_o = 0 in the reset cycle.
